// File: rtl/mvu_pkg.sv
// Shared MVU definitions: bank/quantizer widths and the job-sequencer state encoding.
package mvu_pkg;

  localparam int BWBANKA   = 9;
  localparam int BDBANKA   = 14;
  localparam int BACC      = 32;
  localparam int QMSBLOCBD = 5;
  localparam int QBDOUTBD  = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_QUANT
  } mvu_job_state_t;

endpackage

// File: rtl/mvu_bitpair_gen.sv
// Walks weight/data bit pairs (i,j) in descending significance s=i+j for one vector.
module mvu_bitpair_gen #(
  parameter int BPREC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             adv,
  input  logic [BPREC-1:0] iprec,
  input  logic [BPREC-1:0] jprec,
  output logic [BPREC-1:0] i,
  output logic [BPREC-1:0] j,
  output logic             first_of_s,
  output logic             last
);

  localparam int SW = BPREC + 1;

  logic [SW-1:0]    s_q;
  logic [BPREC-1:0] i_q;
  logic [SW-1:0]    ip_m1, jp_x, s_init, s_dec, i_init_w, i_next_w;

  function automatic logic [SW-1:0] i_hi(input logic [SW-1:0] s, input logic [SW-1:0] ipm1);
    return (s < ipm1) ? s : ipm1;
  endfunction

  function automatic logic [SW-1:0] i_lo(input logic [SW-1:0] s, input logic [SW-1:0] jp);
    return (s >= jp) ? s - jp + SW'(1) : '0;
  endfunction

  assign ip_m1    = {1'b0, iprec} - SW'(1);
  assign jp_x     = {1'b0, jprec};
  assign s_init   = {1'b0, iprec} + jp_x - SW'(2);
  assign s_dec    = s_q - SW'(1);
  assign i_init_w = i_hi(s_init, ip_m1);
  assign i_next_w = i_hi(s_dec, ip_m1);

  assign i          = i_q;
  assign j          = BPREC'(s_q) - i_q;
  assign first_of_s = ({1'b0, i_q} == i_hi(s_q, ip_m1));
  assign last       = (s_q == '0);

  // s only decrements once i has reached the lowest legal index for it; holds at the final pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      i_q <= '0;
    end else if (init) begin
      s_q <= s_init;
      i_q <= BPREC'(i_init_w);
    end else if (adv && !last) begin
      if ({1'b0, i_q} == i_lo(s_q, jp_x)) begin
        s_q <= s_dec;
        i_q <= BPREC'(i_next_w);
      end else begin
        i_q <= i_q - BPREC'(1);
      end
    end
  end

endmodule

// File: rtl/mvu_job_ctrl.sv
// Bit-serial MVU job sequencer: issues per-vector weight/data reads, drains the pipeline, fires the quantizer.
module mvu_job_ctrl #(
  parameter int BWBANKA   = mvu_pkg::BWBANKA,
  parameter int BDBANKA   = mvu_pkg::BDBANKA,
  parameter int BPREC     = 4,
  parameter int BCNT      = 16,
  parameter int QMSBLOCBD = mvu_pkg::QMSBLOCBD,
  parameter int QBDOUTBD  = mvu_pkg::QBDOUTBD,
  parameter int LAT       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BPREC-1:0]     iprec,
  input  logic [BPREC-1:0]     jprec,
  input  logic [BWBANKA-1:0]   wbase,
  input  logic [BDBANKA-1:0]   dbase,
  input  logic [BCNT-1:0]      nvec,
  input  logic [1:0]           mul_mode_in,
  input  logic [QMSBLOCBD-1:0] qmsb_in,
  input  logic [QBDOUTBD-1:0]  qbd_in,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           mul_mode,
  output logic                 acc_clr,
  output logic                 acc_sh,
  output logic [BWBANKA-1:0]   rdw_addr,
  output logic                 rdd_en,
  input  logic                 rdd_grnt,
  output logic [BDBANKA-1:0]   rdd_addr,
  output logic                 quant_clr,
  output logic                 quant_start,
  output logic [QMSBLOCBD-1:0] quant_msbidx,
  output logic [QBDOUTBD-1:0]  quant_bdout
);

  import mvu_pkg::*;

  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

  mvu_job_state_t state_q, state_d;

  logic                 first_q, done_q, err_q;
  logic [DW-1:0]        dcnt_q;
  logic [1:0]           mul_mode_q;
  logic [QMSBLOCBD-1:0] qmsb_q;
  logic [QBDOUTBD-1:0]  qbd_q;
  logic [BPREC-1:0]     iprec_r, jprec_r;
  logic [BWBANKA-1:0]   wbase_r;
  logic [BDBANKA-1:0]   vbase_q;
  logic [BCNT-1:0]      nvec_r, k_q;

  logic             accept, reject, last_vec, gen_init, gen_adv;
  logic [BPREC-1:0] gen_iprec, gen_jprec, bp_i, bp_j;
  logic             bp_first_s, bp_last;

  // Precisions feed the generator straight from the ports on the accepting cycle
  assign gen_iprec = (state_q == ST_IDLE) ? iprec : iprec_r;
  assign gen_jprec = (state_q == ST_IDLE) ? jprec : jprec_r;
  assign last_vec  = (k_q == nvec_r - BCNT'(1));

  mvu_bitpair_gen #(.BPREC(BPREC)) u_bitpair (
    .clk        (clk),
    .rst        (rst),
    .init       (gen_init),
    .adv        (gen_adv),
    .iprec      (gen_iprec),
    .jprec      (gen_jprec),
    .i          (bp_i),
    .j          (bp_j),
    .first_of_s (bp_first_s),
    .last       (bp_last)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    reject   = 1'b0;
    gen_init = 1'b0;
    gen_adv  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (iprec != '0 && jprec != '0 && nvec != '0) begin
            accept   = 1'b1;
            gen_init = 1'b1;
            state_d  = ST_RUN;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (rdd_grnt) begin
          gen_adv = 1'b1;
          if (bp_last) state_d = (LAT == 1) ? ST_QUANT : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == '0) state_d = ST_QUANT;
      end
      ST_QUANT: begin
        if (last_vec) begin
          state_d = ST_IDLE;
        end else begin
          gen_init = 1'b1;
          state_d  = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      first_q    <= 1'b0;
      dcnt_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mul_mode_q <= '0;
      qmsb_q     <= '0;
      qbd_q      <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_QUANT) && last_vec;
      err_q   <= reject;
      if (accept) begin
        first_q    <= 1'b1;
        mul_mode_q <= mul_mode_in;
        qmsb_q     <= qmsb_in;
        qbd_q      <= qbd_in;
      end
      if (state_q == ST_RUN && rdd_grnt) begin
        first_q <= 1'b0;
        if (bp_last) dcnt_q <= DW'(LAT - 2);
      end
      if (state_q == ST_DRAIN) dcnt_q <= dcnt_q - DW'(1);
      if (state_q == ST_QUANT && !last_vec) first_q <= 1'b1;
    end
  end

  // Descriptor and address state: only observed while a job runs, so no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      iprec_r <= iprec;
      jprec_r <= jprec;
      wbase_r <= wbase;
      nvec_r  <= nvec;
      vbase_q <= dbase;
      k_q     <= '0;
    end else if (state_q == ST_QUANT && !last_vec) begin
      k_q     <= k_q + BCNT'(1);
      vbase_q <= vbase_q + BDBANKA'(jprec_r);
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign mul_mode     = mul_mode_q;
  assign rdd_en       = (state_q == ST_RUN);
  assign acc_clr      = rdd_en && first_q;
  assign acc_sh       = rdd_en && bp_first_s && !first_q;
  assign quant_clr    = acc_clr;
  assign rdw_addr     = rdd_en ? wbase_r + BWBANKA'(bp_i) : '0;
  assign rdd_addr     = rdd_en ? vbase_q + BDBANKA'(bp_j) : '0;
  assign quant_start  = (state_q == ST_QUANT);
  assign quant_msbidx = qmsb_q;
  assign quant_bdout  = qbd_q;

endmodule

// File: tb/tb_mvu_job_ctrl.sv
// Directed bench for mvu_job_ctrl: read ordering, stalls, rejects, abort and boundary precisions.
module tb_mvu_job_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  iprec = '0, jprec = '0;
  logic [8:0]  wbase = '0;
  logic [13:0] dbase = '0;
  logic [15:0] nvec = '0;
  logic [1:0]  mul_mode_in = '0;
  logic [4:0]  qmsb_in = '0, qbd_in = '0;
  logic        rdd_grnt = 1'b1;

  logic        busy, done, err, acc_clr, acc_sh, rdd_en, quant_clr, quant_start;
  logic [1:0]  mul_mode;
  logic [8:0]  rdw_addr;
  logic [13:0] rdd_addr;
  logic [4:0]  quant_msbidx, quant_bdout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0, tq, nrd, nsh, nclr;
  logic [8:0]  last_w;
  logic [13:0] last_d;

  mvu_job_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .iprec(iprec), .jprec(jprec),
    .wbase(wbase), .dbase(dbase), .nvec(nvec), .mul_mode_in(mul_mode_in),
    .qmsb_in(qmsb_in), .qbd_in(qbd_in), .busy(busy), .done(done), .err(err),
    .mul_mode(mul_mode), .acc_clr(acc_clr), .acc_sh(acc_sh), .rdw_addr(rdw_addr),
    .rdd_en(rdd_en), .rdd_grnt(rdd_grnt), .rdd_addr(rdd_addr), .quant_clr(quant_clr),
    .quant_start(quant_start), .quant_msbidx(quant_msbidx), .quant_bdout(quant_bdout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk_read(input string tag, input logic clr, input logic sh,
                          input logic [8:0] wa, input logic [13:0] da);
    chk({tag, ".rdd_en"}, 32'(rdd_en), 32'd1);
    chk({tag, ".acc_clr"}, 32'(acc_clr), 32'(clr));
    chk({tag, ".quant_clr"}, 32'(quant_clr), 32'(clr));
    chk({tag, ".acc_sh"}, 32'(acc_sh), 32'(sh));
    chk({tag, ".rdw_addr"}, 32'(rdw_addr), 32'(wa));
    chk({tag, ".rdd_addr"}, 32'(rdd_addr), 32'(da));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".rdd_en"}, 32'(rdd_en), 32'd0);
    chk({tag, ".rdw_addr"}, 32'(rdw_addr), 32'd0);
    chk({tag, ".rdd_addr"}, 32'(rdd_addr), 32'd0);
    chk({tag, ".acc"}, 32'({acc_clr, acc_sh, quant_clr}), 32'd0);
    chk({tag, ".quant_start"}, 32'(quant_start), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
  endtask

  task automatic wait_quant(input string tag, output int at);
    int n;
    n = 0;
    while (quant_start !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    chk({tag, ".quant_start_seen"}, 32'(quant_start), 32'd1);
    at = cyc;
  endtask

  task automatic set_job(input logic [3:0] ip, input logic [3:0] jp, input logic [8:0] wb,
                         input logic [13:0] db, input logic [15:0] nv, input logic [1:0] mm,
                         input logic [4:0] qm, input logic [4:0] qb);
    iprec = ip; jprec = jp; wbase = wb; dbase = db; nvec = nv;
    mul_mode_in = mm; qmsb_in = qm; qbd_in = qb;
  endtask

  initial begin
    // Reset state
    tick();
    chk_quiet("rst");
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.mode_q", 32'({mul_mode, quant_msbidx, quant_bdout}), 32'd0);
    rst = 1'b0;
    tick();

    // 2x2, one vector, grant always high
    set_job(4'd2, 4'd2, 9'h010, 14'h100, 16'd1, 2'd2, 5'd17, 5'd8);
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    chk("t1.mul_mode", 32'(mul_mode), 32'd2);
    chk("t1.msbidx", 32'(quant_msbidx), 32'd17);
    chk("t1.bdout", 32'(quant_bdout), 32'd8);
    chk_read("t1r0", 1'b1, 1'b0, 9'h011, 14'h101); tick();
    chk_read("t1r1", 1'b0, 1'b1, 9'h011, 14'h100); tick();
    chk_read("t1r2", 1'b0, 1'b0, 9'h010, 14'h101); tick();
    chk_read("t1r3", 1'b0, 1'b1, 9'h010, 14'h100); tick();
    chk("t1.drain_rdd_en", 32'(rdd_en), 32'd0);
    chk("t1.drain_busy", 32'(busy), 32'd1);
    wait_quant("t1", tq);
    chk("t1.quant_latency", 32'(tq - t0), 32'd7);
    tick();
    chk("t1.done", 32'(done), 32'd1);
    chk("t1.busy_end", 32'(busy), 32'd0);
    chk("t1.qs_single", 32'(quant_start), 32'd0);
    tick();
    chk("t1.done_pulse", 32'(done), 32'd0);

    // 1x3, three vectors
    set_job(4'd1, 4'd3, 9'h020, 14'h000, 16'd3, 2'd1, 5'd3, 5'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 3; r++) begin
        chk_read($sformatf("t2k%0dr%0d", k, r), r == 0, r != 0, 9'h020, 14'(3 * k + 2 - r));
        tick();
      end
      chk($sformatf("t2k%0d.drain_busy", k), 32'(busy), 32'd1);
      wait_quant($sformatf("t2k%0d", k), tq);
      chk($sformatf("t2k%0d.quant_busy", k), 32'(busy), 32'd1);
      tick();
      chk($sformatf("t2k%0d.done", k), 32'(done), (k == 2) ? 32'd1 : 32'd0);
    end
    tick();

    // 2x2 with reads 1 and 2 each held off for three cycles
    set_job(4'd2, 4'd2, 9'h010, 14'h100, 16'd1, 2'd2, 5'd17, 5'd8);
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    chk_read("t3r0", 1'b1, 1'b0, 9'h011, 14'h101);
    tick();
    for (int c = 0; c < 4; c++) begin
      chk_read($sformatf("t3r1c%0d", c), 1'b0, 1'b1, 9'h011, 14'h100);
      rdd_grnt = (c == 3);
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      chk_read($sformatf("t3r2c%0d", c), 1'b0, 1'b0, 9'h010, 14'h101);
      rdd_grnt = (c == 3);
      tick();
    end
    chk_read("t3r3", 1'b0, 1'b1, 9'h010, 14'h100);
    tick();
    wait_quant("t3", tq);
    chk("t3.quant_latency", 32'(tq - t0), 32'd13);
    tick();
    chk("t3.done", 32'(done), 32'd1);
    tick();

    // Rejected descriptors
    set_job(4'd2, 4'd0, 9'h010, 14'h100, 16'd1, 2'd3, 5'd9, 5'd9);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4a.err", 32'(err), 32'd1);
    chk("t4a.busy", 32'(busy), 32'd0);
    chk("t4a.rdd_en", 32'(rdd_en), 32'd0);
    chk("t4a.mode_kept", 32'(mul_mode), 32'd2);
    tick();
    chk("t4a.err_pulse", 32'(err), 32'd0);
    chk("t4a.busy2", 32'(busy), 32'd0);
    set_job(4'd2, 4'd2, 9'h010, 14'h100, 16'd0, 2'd3, 5'd9, 5'd9);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4b.err", 32'(err), 32'd1);
    chk("t4b.busy", 32'(busy), 32'd0);
    tick();
    chk("t4b.err_pulse", 32'(err), 32'd0);
    chk("t4b.rdd_en", 32'(rdd_en), 32'd0);

    // 1x1, two vectors, reset asserted while draining vector 1
    set_job(4'd1, 4'd1, 9'h030, 14'h200, 16'd2, 2'd1, 5'd6, 5'd7);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_read("t5k0", 1'b1, 1'b0, 9'h030, 14'h200);
    tick();
    wait_quant("t5k0", tq);
    tick();
    chk_read("t5k1", 1'b1, 1'b0, 9'h030, 14'h201);
    tick();
    chk("t5.in_drain", 32'({busy, rdd_en, quant_start}), 32'b100);
    #2 rst = 1'b1;
    #1;
    chk_quiet("t5.async");
    chk("t5.async_mode", 32'({mul_mode, quant_msbidx, quant_bdout}), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("t5.held%0d", c), 32'({quant_start, done, busy}), 32'd0);
    end
    rst = 1'b0;
    tick();
    chk("t5.after_release", 32'({quant_start, done, busy}), 32'd0);
    set_job(4'd2, 4'd2, 9'h010, 14'h100, 16'd1, 2'd2, 5'd17, 5'd8);
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    chk_read("t5n.r0", 1'b1, 1'b0, 9'h011, 14'h101);
    wait_quant("t5n", tq);
    chk("t5n.quant_latency", 32'(tq - t0), 32'd7);
    tick();
    chk("t5n.done", 32'(done), 32'd1);
    tick();

    // start while busy is ignored
    set_job(4'd2, 4'd2, 9'h010, 14'h100, 16'd1, 2'd2, 5'd17, 5'd8);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_read("t6r0", 1'b1, 1'b0, 9'h011, 14'h101);
    set_job(4'd3, 4'd3, 9'h055, 14'h300, 16'd4, 2'd1, 5'd2, 5'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_read("t6r1", 1'b0, 1'b1, 9'h011, 14'h100); tick();
    chk_read("t6r2", 1'b0, 1'b0, 9'h010, 14'h101); tick();
    chk_read("t6r3", 1'b0, 1'b1, 9'h010, 14'h100); tick();
    chk("t6.mul_mode", 32'(mul_mode), 32'd2);
    chk("t6.msbidx", 32'(quant_msbidx), 32'd17);
    wait_quant("t6", tq);
    tick();
    chk("t6.done", 32'(done), 32'd1);
    chk("t6.mode_held", 32'({mul_mode, quant_bdout}), 32'({2'd2, 5'd8}));
    tick();

    // 15x15 with data base near the top of the bank
    set_job(4'd15, 4'd15, 9'h000, 14'h3FFE, 16'd1, 2'd0, 5'd31, 5'd31);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_read("t7r0", 1'b1, 1'b0, 9'd14, 14'd12);
    nrd = 0; nsh = 0; nclr = 0;
    last_w = '0; last_d = '0;
    while (rdd_en === 1'b1 && nrd < 400) begin
      nrd++;
      nsh += int'(acc_sh);
      nclr += int'(acc_clr);
      last_w = rdw_addr;
      last_d = rdd_addr;
      tick();
    end
    chk("t7.reads", 32'(nrd), 32'd225);
    chk("t7.shifts", 32'(nsh), 32'd28);
    chk("t7.clears", 32'(nclr), 32'd1);
    chk("t7.last_w", 32'(last_w), 32'd0);
    chk("t7.last_d", 32'(last_d), 32'h3FFE);
    wait_quant("t7", tq);
    tick();
    chk("t7.done", 32'(done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mvu_job_ctrl.md
Name: mvu_job_ctrl

Overview:
Per-MVU bit-serial job sequencer that replaces hand-driven stimulus of the MVU control inputs. It accepts a job descriptor (precisions, base addresses, vector count), then generates weight/data read addresses and accumulator clear/shift pulses in significance order. It waits out the MVU pipeline and pulses the quantizer once per output vector. One instance sits in front of each MVU; the parameters generalise it to any precision, bank depth and pipeline latency.

Parameters:
BWBANKA, 9, bitwidth of weight bank address
BDBANKA, 14, bitwidth of data bank address
BPREC, 4, width of precision fields; legal precisions 1..2^BPREC-1
BCNT, 16, width of output-vector count
QMSBLOCBD, 5, width of quantizer MSB index (clog2 of BACC=32)
QBDOUTBD, 5, width of quantizer output bit-depth
LAT, 4, cycles from read issue to accumulator update inside the MVU (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  job request, sampled in IDLE only
iprec  in  BPREC  weight precision (bits)
jprec  in  BPREC  data precision (bits)
wbase  in  BWBANKA  weight base address
dbase  in  BDBANKA  data base address of vector 0
nvec  in  BCNT  number of output vectors
mul_mode_in  in  2  multiply mode for the job
qmsb_in  in  QMSBLOCBD  quantizer MSB index for the job
qbd_in  in  QBDOUTBD  quantizer output depth for the job
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
err  out  1  one-cycle pulse: start rejected
mul_mode  out  2  registered mode to MVU
acc_clr  out  1  clear accumulator with this read
acc_sh  out  1  shift accumulator left 1 before adding this read
rdw_addr  out  BWBANKA  weight read address
rdd_en  out  1  data read request
rdd_grnt  in  1  data read granted
rdd_addr  out  BDBANKA  data read address
quant_clr  out  1  quantizer clear pulse
quant_start  out  1  quantizer capture pulse
quant_msbidx  out  QMSBLOCBD  registered qmsb_in
quant_bdout  out  QBDOUTBD  registered qbd_in

Behaviour:
- Reset: every output 0, state IDLE; assertion mid-job aborts immediately with no done pulse.
- States: IDLE, RUN, DRAIN, QUANT.
- IDLE: on start with iprec!=0, jprec!=0 and nvec!=0, latch all descriptor inputs, busy=1 next cycle, go to RUN; otherwise on start pulse err and stay IDLE. start outside IDLE is ignored.
- RUN: per vector k, significance s runs from iprec+jprec-2 down to 0. For each s, i runs from min(s,iprec-1) down to max(0,s-jprec+1), with j=s-i. One read is issued per cycle with rdd_en=1, rdw_addr=wbase+i and rdd_addr=dbase+k*jprec+j. Addresses wrap modulo the bank size.
- acc_clr=1 on the first read of each vector (quant_clr pulses the same cycle). acc_sh=1 on the first read of each new s except the vector's first read. Both are otherwise 0.
- Stall: if rdd_en=1 and rdd_grnt=0, hold all outputs and counters unchanged; the read is re-presented until granted. Reads per vector = iprec*jprec grants.
- DRAIN: entered after the last granted read of the vector. rdd_en=0 and acc_clr=acc_sh=0. Counts LAT-1 cycles, so quant_start=1 exactly LAT cycles after the last granted read's cycle.
- QUANT: quant_start is a single-cycle pulse. If k<nvec-1, RUN resumes with k+1 the next cycle; the quantizer has already captured the result. Otherwise done=1 in the next cycle, busy=0 and state IDLE.
- Precision 1x1 gives one read per vector. Max precision (2^BPREC-1)^2 reads, with no counter overflow.
- mul_mode, quant_msbidx and quant_bdout hold their latched values until the next accepted start.

Decomposition:
- Shared package mvu_pkg holds BWBANKA, BDBANKA, BACC, QMSBLOCBD, QBDOUTBD and the state enum typedef mvu_job_state_t.
- One natural sub-module, mvu_bitpair_gen, produces (i, j, first_of_s, last) for the given precisions with an advance input. It is reusable by the write-back controller.

Test Plan:
- iprec=2, jprec=2, nvec=1, wbase=0x10, dbase=0x100, grant tied 1 -> (i,j) sequence (1,1),(1,0),(0,1),(0,0); rdw_addr 0x11,0x11,0x10,0x10; rdd_addr 0x101,0x100,0x101,0x100; acc_clr only on read 0, acc_sh on reads 1 and 3; quant_start 4 cycles after read 3; done the cycle after.
- iprec=1, jprec=3, nvec=3, dbase=0 -> 3 reads per vector; vector 2 reads rdd_addr 8,7,6; 3 quant_start pulses; one done; busy high throughout.
- Same as first case with rdd_grnt low on reads 1 and 2 for 3 cycles each -> outputs frozen during the stall; identical sequence; quant_start delayed by 6 cycles.
- start with jprec=0, and separately with nvec=0 -> err pulse, busy stays 0, no reads issued.
- Reset asserted during DRAIN of vector 1 of 2 -> all outputs 0 asynchronously; no quant_start or done; a new start after release runs normally.
- start pulsed while busy with different wbase -> ignored; current job addresses unchanged.
